// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
// Optional feature macro used by the top level: BCD_DOWN_AUTORELOAD_EN.
package bcd_timer_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;

   function automatic logic is_bcd(input bcd_digit_t d);
      return (d <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit built from T flip-flops with down-count toggle equations.
// borrow_out fires when this digit is stepped while at 0, so the next digit steps too.
module bcd_down_digit
   import bcd_timer_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       load,
   input  bcd_digit_t d,
   output bcd_digit_t q,
   output logic       borrow_out
);

   bcd_digit_t r_q;
   logic [3:0] w_t;

   // Toggle masks: 0 -> 9 wraps, every other value steps down by one.
   always_comb begin
      w_t[0] = 1'b1;
      w_t[1] = ~r_q[0] & (r_q[1] | r_q[2] | r_q[3]);
      w_t[2] = ~r_q[0] & ~r_q[1] & (r_q[2] | r_q[3]);
      w_t[3] = ~r_q[0] & ~r_q[1] & ~r_q[2];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= 4'd0;
      end else if (load) begin
         r_q <= d;
      end else if (en) begin
         r_q <= r_q ^ w_t;
      end
   end

   assign q          = r_q;
   assign borrow_out = en & (r_q == 4'd0);

endmodule

// File: rtl/bcd_downcount_timer.sv
// Loadable multi-digit BCD countdown timer with load/start/pause control and done pulse.
// Define BCD_DOWN_AUTORELOAD_EN to restart from the last accepted load value at terminal count.
module bcd_downcount_timer
   import bcd_timer_pkg::*;
#(
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  start,
   input  logic                  pause,
   output logic [4*DIGITS-1:0]   Q,
   output logic                  busy,
   output logic                  zero,
   output logic                  done,
   output logic                  load_err
);

   localparam int W = 4 * DIGITS;

   state_t         r_state;
   state_t         w_state_next;
   logic           r_done;
   logic           r_load_err;
   logic           w_done_next;
   logic           w_load_err_next;
   logic [DIGITS-1:0] w_digit_ok;
   logic [DIGITS-1:0] w_en;
   logic [DIGITS-1:0] w_borrow;
   logic [W-1:0]   w_q;
   logic [W-1:0]   w_digit_d;
   logic           w_load_ok;
   logic           w_load_accept;
   logic           w_run_en;
   logic           w_is_one;
   logic           w_reload_now;
   logic           w_digit_load;

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign w_digit_ok[gi] = is_bcd(load_val[4*gi +: 4]);

         if (gi == 0) begin : g_lsd
            assign w_en[gi] = w_run_en;
         end else begin : g_chain
            assign w_en[gi] = w_borrow[gi-1];
         end

         bcd_down_digit u_digit (
            .clk        (clk),
            .rst        (rst),
            .en         (w_en[gi]),
            .load       (w_digit_load),
            .d          (w_digit_d[4*gi +: 4]),
            .q          (w_q[4*gi +: 4]),
            .borrow_out (w_borrow[gi])
         );
      end
   endgenerate

   assign w_load_ok     = &w_digit_ok;
   assign w_load_accept = load & w_load_ok;
   assign w_run_en      = (r_state == RUN) & ~pause & ~load;
   assign w_is_one      = (w_q == W'(1));

`ifdef BCD_DOWN_AUTORELOAD_EN
   logic [W-1:0] r_reload;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_reload <= '0;
      end else if (w_load_accept) begin
         r_reload <= load_val;
      end
   end

   assign w_reload_now = w_run_en & w_is_one & (r_reload != '0);
   assign w_digit_d    = w_load_accept ? load_val : r_reload;
`else
   assign w_reload_now = 1'b0;
   assign w_digit_d    = load_val;
`endif

   assign w_digit_load = w_load_accept | w_reload_now;

   always_comb begin
      w_state_next    = r_state;
      w_done_next     = 1'b0;
      w_load_err_next = 1'b0;
      if (load) begin
         if (w_load_ok) begin
            w_state_next = IDLE;
         end else begin
            w_load_err_next = 1'b1;
         end
      end else if (pause) begin
         if (r_state == RUN) begin
            w_state_next = HOLD;
         end
      end else begin
         case (r_state)
            IDLE: if (start && (w_q != '0)) w_state_next = RUN;
            RUN: begin
               if (w_is_one) begin
                  w_done_next = 1'b1;
                  if (!w_reload_now) w_state_next = IDLE;
               end else if (w_borrow[DIGITS-1]) begin
                  // Unreachable with validated loads; stops a corrupted count from wrapping forever.
                  w_state_next = IDLE;
               end
            end
            HOLD: if (start) w_state_next = RUN;
            default: w_state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_done     <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_done     <= w_done_next;
         r_load_err <= w_load_err_next;
      end
   end

   assign Q        = w_q;
   assign busy     = (r_state == RUN) | (r_state == HOLD);
   assign zero     = (w_q == '0);
   assign done     = r_done;
   assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_downcount_timer.sv
// Scoreboard bench for bcd_downcount_timer: directed plan plus random stimulus against an integer model.
// Honours BCD_DOWN_AUTORELOAD_EN in the reference model.
module tb_bcd_downcount_timer;

   localparam int DIGITS = 2;
   localparam int W      = 4 * DIGITS;

   logic         clk = 1'b0;
   logic         rst;
   logic         load;
   logic [W-1:0] load_val;
   logic         start;
   logic         pause;
   logic [W-1:0] Q;
   logic         busy;
   logic         zero;
   logic         done;
   logic         load_err;

   always #5 clk = ~clk;

   bcd_downcount_timer #(.DIGITS(DIGITS)) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .start    (start),
      .pause    (pause),
      .Q        (Q),
      .busy     (busy),
      .zero     (zero),
      .done     (done),
      .load_err (load_err)
   );

   typedef struct {
      logic [W-1:0] q;
      logic         busy;
      logic         zero;
      logic         done;
      logic         lerr;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: count held as a plain integer, mode as 0=idle 1=run 2=hold
   int   m_val;
   int   m_mode;
   int   m_reload;
   bit   m_done;
   bit   m_lerr;

   function automatic logic [W-1:0] int2bcd(input int n);
      logic [W-1:0] r;
      int v;
      r = '0;
      v = n;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic int bcd2int(input logic [W-1:0] b);
      int acc;
      int p;
      acc = 0;
      p   = 1;
      for (int i = 0; i < DIGITS; i++) begin
         acc = acc + int'(b[4*i +: 4]) * p;
         p   = p * 10;
      end
      return acc;
   endfunction

   function automatic bit bcd_ok(input logic [W-1:0] b);
      for (int i = 0; i < DIGITS; i++)
         if (b[4*i +: 4] > 4'd9) return 1'b0;
      return 1'b1;
   endfunction

   function automatic exp_t model_expect();
      exp_t e;
      e.q    = int2bcd(m_val);
      e.busy = (m_mode != 0);
      e.zero = (m_val == 0);
      e.done = m_done;
      e.lerr = m_lerr;
      return e;
   endfunction

   task automatic model_reset();
      m_val    = 0;
      m_mode   = 0;
      m_reload = 0;
      m_done   = 1'b0;
      m_lerr   = 1'b0;
   endtask

   task automatic model_step(input logic l, input logic [W-1:0] lv, input logic s, input logic p);
      m_done = 1'b0;
      m_lerr = 1'b0;
      if (l) begin
         if (bcd_ok(lv)) begin
            m_val    = bcd2int(lv);
            m_reload = m_val;
            m_mode   = 0;
         end else begin
            m_lerr = 1'b1;
         end
      end else if (p) begin
         if (m_mode == 1) m_mode = 2;
      end else if (m_mode == 0) begin
         if (s && m_val != 0) m_mode = 1;
      end else if (m_mode == 2) begin
         if (s) m_mode = 1;
      end else begin
         m_val = m_val - 1;
         if (m_val == 0) begin
            m_done = 1'b1;
`ifdef BCD_DOWN_AUTORELOAD_EN
            if (m_reload != 0) m_val = m_reload;
            else m_mode = 0;
`else
            m_mode = 0;
`endif
         end
      end
   endtask

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, want);
      end
   endtask

   // Monitor: pops one expectation per clock and compares just after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("Q", Q, e.q);
            check("busy", W'(busy), W'(e.busy));
            check("zero", W'(zero), W'(e.zero));
            check("done", W'(done), W'(e.done));
            check("load_err", W'(load_err), W'(e.lerr));
            $display("txn t=%0t Q=%h busy=%b zero=%b done=%b load_err=%b", $time, Q, busy, zero, done, load_err);
         end
      end
   end

   task automatic cyc(input logic l, input logic [W-1:0] lv, input logic s, input logic p);
      @(posedge clk);
      #2;
      rst      = 1'b0;
      load     = l;
      load_val = lv;
      start    = s;
      pause    = p;
      model_step(l, lv, s, p);
      exp_q.push_back(model_expect());
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst   = 1'b1;
      load  = 1'b0;
      start = 1'b0;
      pause = 1'b0;
      model_reset();
      exp_q.push_back(model_expect());
      #1;
      check("rst_async_Q", Q, W'(0));
      check("rst_async_busy", W'(busy), W'(0));
      check("rst_async_done", W'(done), W'(0));
   endtask

   function automatic logic [W-1:0] rand_load();
      logic [W-1:0] v;
      if ($urandom_range(0, 7) == 0) begin
         v = W'($urandom);
         if (bcd_ok(v)) v[3:0] = 4'($urandom_range(10, 15));
      end else begin
         v = int2bcd(int'($urandom_range(0, 25)));
      end
      return v;
   endfunction

   initial begin
      logic         l;
      logic         s;
      logic         p;
      logic [W-1:0] lv;

      rst      = 1'b1;
      load     = 1'b0;
      load_val = '0;
      start    = 1'b0;
      pause    = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      check("reset_Q", Q, W'(0));
      check("reset_busy", W'(busy), W'(0));
      check("reset_zero", W'(zero), W'(1));
      check("reset_done", W'(done), W'(0));
      check("reset_load_err", W'(load_err), W'(0));

      // Full countdown from 12
      cyc(1'b1, 8'h12, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      repeat (15) cyc(1'b0, 8'h00, 1'b0, 1'b0);

      // Digit wrap with borrow: 20 -> 19 ... 10 -> 09
      cyc(1'b1, 8'h20, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      repeat (12) cyc(1'b0, 8'h00, 1'b0, 1'b0);

      // Pause at 07 for three cycles, then resume
      cyc(1'b1, 8'h10, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      repeat (8) cyc(1'b0, 8'h00, 1'b0, 1'b0);

      // Invalid load rejected; start at zero ignored
      cyc(1'b1, 8'h3A, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b1, 8'hA4, 1'b0, 1'b0);
      cyc(1'b1, 8'h00, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);

      // Reset mid-count, then load and start together
      cyc(1'b1, 8'h09, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      repeat (4) cyc(1'b0, 8'h00, 1'b0, 1'b0);
      do_reset();
      cyc(1'b1, 8'h05, 1'b1, 1'b0);
      repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);

      // Short count, exercises reload when the feature is built in
      cyc(1'b1, 8'h03, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      repeat (10) cyc(1'b0, 8'h00, 1'b0, 1'b0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
         end else begin
            l  = ($urandom_range(0, 99) < 6);
            lv = rand_load();
            s  = ($urandom_range(0, 4) == 0);
            p  = ($urandom_range(0, 9) == 0);
            cyc(l, lv, s, p);
         end
      end

      repeat (2) @(posedge clk);
      #3;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain pending=%0d expected=0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bcd_downcount_timer.md
Name: bcd_downcount_timer

Overview:
Multi-digit loadable BCD down-counter/timer; the decrementing counterpart of the team's BCD up-counter.
- Each digit uses T flip-flops with down-count toggle equations; digits are chained by borrow.
- A small control FSM handles load/start/pause and raises a one-cycle done pulse when the count reaches 0.
- Used as a countdown timer feeding the 7-segment display path.

Parameters:
DIGITS, 2, number of BCD digits (1..8); count range 0 .. 10^DIGITS-1

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
load  input  1  load load_val into Q (highest priority)
load_val  input  4*DIGITS  BCD load value, digit 0 in bits [3:0]
start  input  1  begin/resume counting
pause  input  1  suspend counting
Q  output  4*DIGITS  current BCD count
busy  output  1  high in RUN or HOLD
zero  output  1  combinational, Q == 0
done  output  1  registered one-cycle pulse on terminal count
load_err  output  1  registered one-cycle pulse: load_val had a digit > 9

Behaviour:
- Clock and reset: clock clk; reset rst, asynchronous, active-high.
- Reset values: Q=0, state=IDLE, busy=0, done=0, load_err=0; zero=1.
- FSM states:
  - IDLE: not counting.
  - RUN: Q decrements by 1 on every clk edge with pause=0.
  - HOLD: Q frozen.
- Priority per edge: load > pause > start.
- load (any state):
  - All digits <= 9: Q<=load_val, state<=IDLE, load_err<=0.
  - Any digit > 9: Q and state unchanged, load_err<=1 for one cycle.
- IDLE + start:
  - Q!=0: state<=RUN. The first decrement occurs on the next edge.
  - Q==0: ignored. State stays IDLE, no done.
- RUN + pause: state<=HOLD. No decrement on that edge.
- HOLD + start with pause=0: state<=RUN.
- RUN + start has no effect.
- Terminal: on the RUN edge where Q==1 (all other digits 0), Q<=0, state<=IDLE, done<=1.
  - done deasserts on the following edge.
  - Loading L then start yields exactly L decrement edges; done is visible in the same cycle Q first reads 0.
- Digit decrement (per digit, T-FF form, active when its borrow-in en=1):
  - T0=1
  - T1=~Q0&(Q1|Q2|Q3)
  - T2=~Q0&~Q1&(Q2|Q3)
  - T3=~Q0&~Q1&~Q2
  - Q<=Q^T.
  - Gives 0->9 wrap, 8->7, 1->0, etc.
- Borrow chain:
  - Digit 0 en = (state==RUN & ~pause & ~load).
  - Digit k en = digit k-1 en & (digit k-1 == 0).
  - Full-width underflow never occurs, because RUN exits at 1->0.
- Reset mid-count: immediately Q=0, IDLE, done=0. No done pulse is generated.
- A non-BCD digit is never held in Q (invalid loads are rejected).

Optional Feature:
BCD_DOWN_AUTORELOAD_EN
- Defined:
  - A reload register (reset 0) captures every accepted load_val.
  - On the terminal edge, if reload!=0: Q<=reload, state stays RUN, done<=1. Periodic done every L cycles.
  - If reload==0, behaves as without the feature.
  - pause/HOLD still apply.
- Undefined: no reload register; behaviour as in the non-feature description (stops at 0, returns to IDLE).

Decomposition:
- Package bcd_timer_pkg:
  - typedef logic [3:0] bcd_digit_t
  - enum state_t {IDLE, RUN, HOLD}
  - constant BCD_MAX=4'd9
  - function is_bcd(bcd_digit_t)
- Sub-module bcd_down_digit: ports clk, rst, en, load, d, q[3:0], borrow_out (=en & q==0).
  - Instantiated DIGITS times in a generate loop.
- Top level holds the FSM, load validation, done/load_err registers and optional reload register.

Test Plan:
1. DIGITS=2, load 0x12, start; no pause -> Q steps 12,11,10,09 ... 01,00. done high only in the cycle Q=00, 12 edges after the RUN entry edge. busy low afterwards.
2. Load 0x20, start, run 1 decrement -> Q=19 (0->9 digit wrap with borrow). Continue to Q=10 -> next Q=09.
3. In RUN at Q=07, pause for 3 cycles -> Q holds 07 and busy stays 1. start -> decrement resumes: 06.
4. Load 0x3A -> load_err pulses 1 cycle, Q unchanged. Load 0x00 then start -> stays IDLE, no done.
5. Assert rst at Q=05 in RUN -> Q=00 immediately, done=0, busy=0. Load+start in the same cycle -> load wins, IDLE.
6. With BCD_DOWN_AUTORELOAD_EN: load 0x03, start -> Q 03,02,01,03,02,01 ...; done pulses every 3 cycles coincident with the reload.
